pd_drive_cmd: RTL and testbench
===============================

Name: pd_drive_cmd

Overview:
Downstream consumer of the PD math stage. It sums the signed P and D terms, scales the sum by a soft-start gain that ramps up and down under a small state machine, and applies a differential steering offset. It then saturates and registers signed left/right wheel speed commands for the motor-drive/PWM stage. The block also flags excessive speed commands.

Parameters:
RAMP_DIV, 16, clock cycles per 1-LSB step of the 8-bit soft-start scale (min 1)
TOO_FAST, 1536, magnitude threshold for too_fast; positive, at most 2047

Ports:
clk  in  1  system clock (50 MHz), all logic on posedge
rst_n  in  1  synchronous, active-low reset
vld  in  1  pterm/dterm valid this cycle, aligned with PD stage outputs
en  in  1  drive enable (rider present); level sensitive
pterm  in  10  signed P term
dterm  in  12  signed D term
steer  in  12  signed steering offset
lft_spd  out  12  signed left wheel speed command, registered
rght_spd  out  12  signed right wheel speed command, registered
spd_vld  out  1  one-cycle pulse: lft_spd/rght_spd updated this cycle
too_fast  out  1  registered; |lft_spd| or |rght_spd| > TOO_FAST
ramp_done  out  1  high while state is RUN

Behaviour:
- Reset (rst_n low at posedge): lft_spd=0, rght_spd=0, spd_vld=0, too_fast=0, ramp_done=0, state=OFF, scale=0, divider count=0. All pipeline valids are cleared, so in-flight samples are dropped and produce no spd_vld.
- Stage 1 (capture on vld): pd_sum = sext13(pterm) + sext13(dterm). Range is -2560..2558, so no overflow. steer is captured alongside.
- Stage 2: prod = pd_sum * {1'b0, scale}, 22-bit signed. scaled = prod >>> 8, arithmetic, truncated toward -inf, kept at 13 bits. Uses the scale register value at this edge. steer_g = steer if scale != 0, else 0.
- Stage 3: lft_raw = sext14(scaled) + sext14(steer_g); rght_raw = sext14(scaled) - sext14(steer_g). Each is saturated to the 12-bit range [-2048, 2047] and registered into lft_spd/rght_spd. too_fast is computed from the saturated values and registered in the same edge.
- Latency: vld high in cycle 0 gives new outputs and spd_vld=1 in cycle 3. Fully pipelined: vld on consecutive cycles gives spd_vld on consecutive cycles.
- Outputs hold their value when spd_vld=0.
- Soft-start FSM (states OFF, RAMP_UP, RUN, RAMP_DOWN):
  - The divider count is reset to 0 on every state change. In RAMP_UP/RAMP_DOWN it counts 0..RAMP_DIV-1 and wraps.
  - OFF: scale=0. en=1 goes to RAMP_UP.
  - RAMP_UP: scale+=1 on each edge where count==RAMP_DIV-1. The edge that writes scale=255 also moves to RUN. en=0 moves to RAMP_DOWN with scale retained.
  - RUN: scale=255. en=0 moves to RAMP_DOWN.
  - RAMP_DOWN: scale-=1 on each edge where count==RAMP_DIV-1. The edge that writes scale=0 also moves to OFF. en=1 moves to RAMP_UP with scale retained.
  - If en toggles on the same edge as a terminal count, the state change wins and scale is not stepped.
- The scale register never wraps: it never goes below 0 or above 255.

Test Plan:
- Reset, then en=0, vld=1, pterm=100, dterm=200, steer=300 -> spd_vld pulses in cycle 3; lft_spd=0, rght_spd=0 (scale 0, steer gated); too_fast=0.
- en=1 held, RAMP_DIV=16 -> ramp_done=1 exactly 4081 edges after en is first sampled high (1 edge to enter RAMP_UP plus 255*16); scale=255.
- In RUN: pterm=100, dterm=200, steer=0 -> lft=rght=298. pterm=-100, dterm=-200 -> lft=rght=-299 (floor).
- In RUN: pterm=511, dterm=2047, steer=500 -> scaled=2548; lft=2047 (sat), rght=2047 (sat); too_fast=1. With steer=-500 and pd terms 0 -> lft=-500, rght=500, too_fast=0.
- en dropped mid RAMP_UP at scale=100 -> RAMP_DOWN next edge; scale reaches 0 after 1600 more edges, then OFF. en re-raised at scale=40 -> RAMP_UP resumes from 40.
- vld on 3 consecutive cycles, then rst_n low for 1 cycle after the second -> no further spd_vld; all outputs 0 and state OFF after reset.

Source files
------------

// File: rtl/pd_drive_cmd.sv
// PD drive command: sums P and D terms, applies a soft-start gain and a steering
// offset, then saturates into registered signed left/right wheel speed commands.
module pd_drive_cmd #(
    parameter int RAMP_DIV = 16,
    parameter int TOO_FAST = 1536
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               en,
    input  logic signed [9:0]  pterm,
    input  logic signed [11:0] dterm,
    input  logic signed [11:0] steer,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               spd_vld,
    output logic               too_fast,
    output logic               ramp_done
);
    localparam int STAGES = 3;
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {OFF, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t          state;
    logic [7:0]      scale;
    logic [CW-1:0]   cnt;
    logic            tc;

    assign tc = (cnt == CNT_MAX);

    // Any state change clears the divider and takes priority over a scale step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= OFF;
            scale     <= 8'd0;
            cnt       <= '0;
            ramp_done <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    scale <= 8'd0;
                    cnt   <= '0;
                    if (en) state <= RAMP_UP;
                end
                RAMP_UP: begin
                    if (!en) begin
                        state <= RAMP_DOWN;
                        cnt   <= '0;
                    end else if (tc) begin
                        cnt <= '0;
                        if (scale >= 8'd254) begin
                            scale     <= 8'd255;
                            state     <= RUN;
                            ramp_done <= 1'b1;
                        end else begin
                            scale <= scale + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    scale <= 8'd255;
                    cnt   <= '0;
                    if (!en) begin
                        state     <= RAMP_DOWN;
                        ramp_done <= 1'b0;
                    end
                end
                RAMP_DOWN: begin
                    if (en) begin
                        state <= RAMP_UP;
                        cnt   <= '0;
                    end else if (tc) begin
                        cnt <= '0;
                        if (scale <= 8'd1) begin
                            scale <= 8'd0;
                            state <= OFF;
                        end else begin
                            scale <= scale - 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= OFF;
                    scale     <= 8'd0;
                    cnt       <= '0;
                    ramp_done <= 1'b0;
                end
            endcase
        end
    end

    logic [STAGES-1:0]   vld_pipe;
    logic signed [12:0]  sum1;
    logic signed [11:0]  steer1, steer2;
    logic signed [12:0]  scaled2;
    logic signed [21:0]  prod;
    logic signed [13:0]  lft_raw, rght_raw;
    logic signed [11:0]  lft_sat, rght_sat;

    function automatic logic signed [11:0] sat12(input logic signed [13:0] x);
        if (x > 14'sd2047)       return 12'h7FF;
        else if (x < -14'sd2048) return 12'h800;
        else                     return x[11:0];
    endfunction

    function automatic logic is_fast(input logic signed [11:0] v);
        return (v > TOO_FAST) || (v < -TOO_FAST);
    endfunction

    // Unsigned scale; product floor-divided by 256 via arithmetic shift.
    assign prod     = $signed({{9{sum1[12]}}, sum1}) * $signed({14'd0, scale});
    assign lft_raw  = {scaled2[12], scaled2} + {{2{steer2[11]}}, steer2};
    assign rght_raw = {scaled2[12], scaled2} - {{2{steer2[11]}}, steer2};
    assign lft_sat  = sat12(lft_raw);
    assign rght_sat = sat12(rght_raw);
    assign spd_vld  = vld_pipe[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sum1     <= '0;
            steer1   <= '0;
            scaled2  <= '0;
            steer2   <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], vld};
            if (vld) begin
                sum1   <= {{3{pterm[9]}}, pterm} + {dterm[11], dterm};
                steer1 <= steer;
            end
            if (vld_pipe[0]) begin
                scaled2 <= prod[20:8];
                steer2  <= (scale != 8'd0) ? steer1 : 12'sd0;
            end
            if (vld_pipe[1]) begin
                lft_spd  <= lft_sat;
                rght_spd <= rght_sat;
                too_fast <= is_fast(lft_sat) || is_fast(rght_sat);
            end
        end
    end
endmodule

// File: tb/tb_pd_drive_cmd.sv
// Scoreboard bench for pd_drive_cmd: expected commands are queued at drive time
// and compared whenever spd_vld pulses; soft-start timing is checked by edge counts.
module tb_pd_drive_cmd;
    logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, en = 1'b0;
    logic signed [9:0]  pterm = '0;
    logic signed [11:0] dterm = '0, steer = '0;
    logic signed [11:0] lft_spd, rght_spd;
    logic spd_vld, too_fast, ramp_done;

    int total = 0, bad = 0;

    typedef struct {
        logic signed [11:0] l;
        logic signed [11:0] r;
        logic               tf;
    } exp_t;
    exp_t q[$];

    pd_drive_cmd #(.RAMP_DIV(16), .TOO_FAST(1536)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .en(en),
        .pterm(pterm), .dterm(dterm), .steer(steer),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld),
        .too_fast(too_fast), .ramp_done(ramp_done)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (spd_vld === 1'b1) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_spd_vld: got lft=%0d rght=%0d, required no output", lft_spd, rght_spd);
            end else begin
                e = q.pop_front();
                if (lft_spd !== e.l || rght_spd !== e.r || too_fast !== e.tf) begin
                    bad++;
                    $display("FAIL spd_cmd: got lft=%0d rght=%0d tf=%0b, required lft=%0d rght=%0d tf=%0b",
                             lft_spd, rght_spd, too_fast, e.l, e.r, e.tf);
                end
            end
        end
    end

    function automatic int sat(input int x);
        return (x > 2047) ? 2047 : (x < -2048) ? -2048 : x;
    endfunction

    // Drive one sample for one cycle and queue its expected result.
    task automatic send(input int p, input int d, input int s, input int sc);
        exp_t e;
        int scaled, sg, l, r;
        scaled = ((p + d) * sc) >>> 8;
        sg = (sc != 0) ? s : 0;
        l = sat(scaled + sg);
        r = sat(scaled - sg);
        e.l = 12'(l);
        e.r = 12'(r);
        e.tf = (l > 1536 || l < -1536 || r > 1536 || r < -1536);
        q.push_back(e);
        vld = 1'b1; pterm = 10'(p); dterm = 12'(d); steer = 12'(s);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        vld = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Advances edges until dut.scale equals target; returns edges taken or -1.
    task automatic edges_to_scale(input int target, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (dut.scale == 8'(target)) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({lft_spd, rght_spd, spd_vld, too_fast, ramp_done} !== 27'd0 || dut.scale !== 8'd0) begin
            bad++;
            $display("FAIL reset: got lft=%0d rght=%0d vld=%0b tf=%0b rd=%0b scale=%0d, required all 0",
                     lft_spd, rght_spd, spd_vld, too_fast, ramp_done, dut.scale);
        end
    endtask

    task automatic test_off_gating();
        logic [2:0] seen;
        @(posedge clk); #1;
        send(100, 200, 300, 0);
        vld = 1'b0;
        @(negedge clk); seen[0] = spd_vld;
        @(negedge clk); seen[1] = spd_vld;
        @(negedge clk); seen[2] = spd_vld;
        total++;
        if (seen !== 3'b100) begin
            bad++;
            $display("FAIL latency: got spd_vld cycles1..3=%b, required 100", seen);
        end
        drain();
    endtask

    task automatic test_ramp_up();
        int n;
        en = 1'b1;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            if (ramp_done) begin n = i; break; end
        end
        total++;
        if (n != 4081 || dut.scale !== 8'd255) begin
            bad++;
            $display("FAIL ramp_up: got edges=%0d scale=%0d, required edges=4081 scale=255", n, dut.scale);
        end
    endtask

    task automatic test_run_math();
        send(100, 200, 0, 255);
        send(-100, -200, 0, 255);
        send(511, 2047, 500, 255);
        send(0, 0, -500, 255);
        send(0, 0, 1536, 255);
        send(0, 0, 1537, 255);
        send(0, 0, -2048, 255);
        send(-512, -2048, 2047, 255);
        send(100, 200, 0, 255);
        drain();
    endtask

    task automatic test_ramp_updown();
        int n;
        en = 1'b0;
        edges_to_scale(0, 5000, n);
        total++;
        if (n != 4081 || ramp_done !== 1'b0) begin
            bad++;
            $display("FAIL ramp_down_full: got edges=%0d rd=%0b, required edges=4081 rd=0", n, ramp_done);
        end
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (dut.scale !== 8'd0 || ramp_done !== 1'b0) begin
            bad++;
            $display("FAIL off_hold: got scale=%0d rd=%0b, required scale=0 rd=0", dut.scale, ramp_done);
        end
        en = 1'b1;
        edges_to_scale(100, 3000, n);
        total++;
        if (n != 1601) begin
            bad++;
            $display("FAIL up_to_100: got edges=%0d, required 1601", n);
        end
        en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dut.scale !== 8'd100 || ramp_done !== 1'b0) begin
            bad++;
            $display("FAIL drop_mid_ramp: got scale=%0d rd=%0b, required scale=100 rd=0", dut.scale, ramp_done);
        end
        edges_to_scale(0, 3000, n);
        total++;
        if (n != 1600) begin
            bad++;
            $display("FAIL down_from_100: got edges=%0d, required 1600", n);
        end
        en = 1'b1;
        edges_to_scale(50, 2000, n);
        en = 1'b0;
        edges_to_scale(40, 1000, n);
        total++;
        if (n != 161) begin
            bad++;
            $display("FAIL down_50_to_40: got edges=%0d, required 161", n);
        end
        en = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dut.scale !== 8'd40) begin
            bad++;
            $display("FAIL reraise_hold: got scale=%0d, required 40", dut.scale);
        end
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (dut.scale !== 8'd40) begin
            bad++;
            $display("FAIL reraise_early: got scale=%0d, required 40", dut.scale);
        end
        @(posedge clk); #1;
        total++;
        if (dut.scale !== 8'd41) begin
            bad++;
            $display("FAIL reraise_step: got scale=%0d, required 41", dut.scale);
        end
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            if (ramp_done) begin n = i; break; end
        end
        total++;
        if (n != 214 * 16) begin
            bad++;
            $display("FAIL reramp_run: got edges=%0d, required %0d", n, 214 * 16);
        end
    endtask

    task automatic test_reset_flush();
        int vcount;
        vld = 1'b1; pterm = 10'sd100; dterm = 12'sd200; steer = 12'sd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        vld = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({lft_spd, rght_spd, too_fast, ramp_done} !== 26'd0 || dut.scale !== 8'd0) begin
            bad++;
            $display("FAIL flush_outputs: got lft=%0d rght=%0d tf=%0b rd=%0b scale=%0d, required all 0",
                     lft_spd, rght_spd, too_fast, ramp_done, dut.scale);
        end
        vcount = (spd_vld === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (spd_vld === 1'b1) vcount++;
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL flush_spd_vld: got %0d pulses, required 0", vcount);
        end
    endtask

    initial begin
        test_reset();
        test_off_gating();
        test_ramp_up();
        test_run_math();
        test_ramp_updown();
        test_reset_flush();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
